// File: rtl/mem_access_ctrl_if.sv
// Shared memory-bus bundle between the fetch/data requesters, the access
// controller and the ROM/RAM arrays.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    // Data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    // Memory arrays
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              rom_en;
    logic              ram_en;
    logic [DATA_W-1:0] mem_rdata;

    // Controller side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, d_gnt, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_rd, mem_wr, rom_en, ram_en
    );

    // Requesters and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, d_gnt, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, rom_en, ram_en
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter and sequencer for the shared ROM/RAM bus. Fetch and
// data requests are serialised through IDLE -> ACCESS -> RESP, with
// per-region wait states and registered read data.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] RomWaitCnt = 4'(ROM_WAIT);
    localparam logic [3:0] RamWaitCnt = 4'(RAM_WAIT);
    localparam logic       PortFetch  = 1'b0;
    localparam logic       PortData   = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              sel_data;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic              if_gnt, d_gnt, d_err;
    logic              mem_rd, mem_wr, rom_en, ram_en;

    // Next-state, capture and strobe decode
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        d_err       = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        rom_en      = 1'b0;
        ram_en      = 1'b0;

        // Data wins when alone, or on a tie when fetch was served last
        sel_data = bus.d_req & (~bus.if_req | (last_q == PortFetch));
        sel_addr = sel_data ? bus.d_addr : bus.if_addr;
        sel_we   = sel_data & bus.d_we;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    owner_d = sel_data ? PortData : PortFetch;
                    last_d  = sel_data ? PortData : PortFetch;
                    we_d    = sel_we;
                    if (sel_we && !sel_addr[ADDR_W-1]) begin
                        // ROM write: never touches the bus, completes with error
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d      = 1'b0;
                        mem_addr_d = sel_addr;
                        if (sel_data) begin
                            mem_wdata_d = bus.d_wdata;
                        end
                        cnt_d   = sel_addr[ADDR_W-1] ? RamWaitCnt : RomWaitCnt;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                rom_en = ~mem_addr_q[ADDR_W-1];
                ram_en = mem_addr_q[ADDR_W-1];
                mem_rd = ~we_q;
                // Write strobe only on the last cycle so wait states give address setup
                mem_wr = we_q & (cnt_q == 4'd0);
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (!we_q) begin
                        if (owner_q == PortData) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if_gnt  = (owner_q == PortFetch);
                d_gnt   = (owner_q == PortData);
                d_err   = (owner_q == PortData) & err_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and capture registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= PortFetch;
            last_q      <= PortFetch;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.rom_en    = rom_en;
    assign bus.ram_en    = ram_en;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random single-requester
// traffic checked against a latency/memory reference model.
module tb_mem_access_ctrl;

    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int W_ROM  = 1;
    localparam int W_RAM  = 0;

    logic clk;
    logic rst;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_WAIT(W_ROM),
        .RAM_WAIT(W_RAM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory arrays (environment) and the expected RAM contents (model)
    logic [7:0] rom_mem [4096];
    logic [7:0] ram_mem [4096];
    logic [7:0] ref_ram [4096];
    logic [7:0] exp_if_rdata;
    logic [7:0] exp_d_rdata;

    int total;
    int bad;

    assign bus.mem_rdata = bus.rom_en ? rom_mem[bus.mem_addr[11:0]] : ram_mem[bus.mem_addr[11:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; RAM array commits a write seen stable before the edge
    task automatic tick();
        logic        wr;
        logic [11:0] wa;
        logic [7:0]  wd;
        @(negedge clk);
        wr = bus.mem_wr & bus.ram_en;
        wa = bus.mem_addr[11:0];
        wd = bus.mem_wdata;
        @(posedge clk);
        if (wr) ram_mem[wa] = wd;
        #1;
        if (bus.if_gnt || bus.d_gnt) check("one_gnt", {31'd0, bus.if_gnt & bus.d_gnt}, 32'd0);
    endtask

    // One transaction from an idle controller on a single port
    task automatic xact(input string tag, input bit port_d, input bit we, input logic [12:0] addr,
                        input logic [7:0] wd, input bit chg, input logic [12:0] addr2);
        int          lat, exp_lat, w;
        int          n_rd, n_wr, n_rom, n_ram, n_bad_addr, n_other, n_err_early;
        bit          got, rom, prot, rd;
        logic [12:0] addr_before;
        rom  = (addr[12] == 1'b0);
        prot = port_d && we && rom;
        rd   = !(port_d && we);
        w    = rom ? W_ROM : W_RAM;
        exp_lat = prot ? 1 : w + 2;
        addr_before = bus.mem_addr;
        n_rd = 0; n_wr = 0; n_rom = 0; n_ram = 0; n_bad_addr = 0; n_other = 0; n_err_early = 0;
        if (port_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        got = 0;
        lat = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (chg && lat == 1) begin
                if (port_d) bus.d_addr = addr2;
                else        bus.if_addr = addr2;
            end
            if (bus.mem_rd) n_rd++;
            if (bus.mem_wr) n_wr++;
            if (bus.rom_en) n_rom++;
            if (bus.ram_en) n_ram++;
            if ((bus.rom_en || bus.ram_en) && bus.mem_addr !== addr) n_bad_addr++;
            if (bus.d_err && !bus.d_gnt) n_err_early++;
            if (port_d ? bus.if_gnt : bus.d_gnt) n_other++;
            if (port_d ? bus.d_gnt : bus.if_gnt) got = 1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rd_cycles"}, n_rd, (!prot && rd) ? w + 1 : 0);
        check({tag, "_wr_cycles"}, n_wr, (!prot && !rd) ? 1 : 0);
        check({tag, "_rom_en"}, n_rom, (!prot && rom) ? w + 1 : 0);
        check({tag, "_ram_en"}, n_ram, (!prot && !rom) ? w + 1 : 0);
        check({tag, "_addr"}, n_bad_addr, 0);
        check({tag, "_other_gnt"}, n_other, 0);
        check({tag, "_err_stray"}, n_err_early, 0);
        if (port_d) begin
            check({tag, "_err"}, {31'd0, bus.d_err}, {31'd0, prot});
            if (rd) exp_d_rdata = rom ? rom_mem[addr[11:0]] : ref_ram[addr[11:0]];
        end else begin
            exp_if_rdata = rom ? rom_mem[addr[11:0]] : ref_ram[addr[11:0]];
        end
        if (port_d && we && !rom) ref_ram[addr[11:0]] = wd;
        if (prot) check({tag, "_addr_hold"}, bus.mem_addr, addr_before);
        check({tag, "_d_rdata"}, bus.d_rdata, exp_d_rdata);
        check({tag, "_if_rdata"}, bus.if_rdata, exp_if_rdata);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
    endtask

    initial begin
        int          seq [$];
        int          at [$];
        int          k;
        logic [7:0]  ram_before;
        bit          pd, we;
        logic [12:0] a;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = 8'($urandom);
            ram_mem[i] = 8'($urandom);
            ref_ram[i] = ram_mem[i];
        end
        rom_mem[16] = 8'h3C;
        exp_if_rdata = 8'h00;
        exp_d_rdata  = 8'h00;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {bus.if_gnt, bus.d_gnt, bus.d_err, bus.mem_rd, bus.mem_wr, bus.rom_en,
                             bus.ram_en, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata},
              32'd0);
        rst = 1'b0;

        // Both requesters held from reset: data, fetch, data, fetch
        bus.d_we = 1'b0; bus.d_addr = 13'h1040; bus.if_addr = 13'h1041;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        k = 0;
        while (seq.size() < 4 && k < 60) begin
            tick();
            k++;
            if (bus.d_gnt) begin seq.push_back(1); at.push_back(k); end
            if (bus.if_gnt) begin seq.push_back(0); at.push_back(k); end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        while (seq.size() < 4) begin seq.push_back(9); at.push_back(999); end
        check("rr_first_lat", at[0], W_RAM + 2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_order%0d", i), seq[i], (i % 2 == 0) ? 1 : 0);
            if (i > 0) check($sformatf("rr_gap%0d", i), at[i] - at[i-1], W_RAM + 3);
        end
        exp_d_rdata  = ref_ram[12'h040];
        exp_if_rdata = ref_ram[12'h041];
        check("rr_d_rdata", bus.d_rdata, exp_d_rdata);
        check("rr_if_rdata", bus.if_rdata, exp_if_rdata);
        tick();

        // Reset in the middle of a RAM write
        ram_before = ram_mem[12'h005];
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 13'h1005; bus.d_wdata = 8'hA5;
        tick();
        check("rst_mid_in_access", {31'd0, bus.ram_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outs", {bus.if_gnt, bus.d_gnt, bus.d_err, bus.mem_rd, bus.mem_wr, bus.rom_en,
                               bus.ram_en, bus.mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.d_req = 1'b0;
        exp_if_rdata = 8'h00;
        exp_d_rdata  = 8'h00;
        k = 0;
        repeat (4) begin
            tick();
            if (bus.if_gnt || bus.d_gnt || bus.mem_wr || bus.mem_rd) k++;
        end
        check("rst_mid_quiet", k, 0);
        check("rst_mid_no_write", ram_mem[12'h005], ram_before);

        // Directed scenarios
        xact("rom_fetch", 1'b0, 1'b0, 13'h0010, 8'h00, 1'b0, 13'h0000);
        check("rom_fetch_3c", bus.if_rdata, 8'h3C);
        xact("ram_wr", 1'b1, 1'b1, 13'h1020, 8'h5A, 1'b0, 13'h0000);
        xact("ram_rd", 1'b1, 1'b0, 13'h1020, 8'h00, 1'b0, 13'h0000);
        check("ram_rd_5a", bus.d_rdata, 8'h5A);
        xact("rom_wr_prot", 1'b1, 1'b1, 13'h0003, 8'h77, 1'b0, 13'h0000);
        xact("addr_chg", 1'b0, 1'b0, 13'h0010, 8'h00, 1'b1, 13'h1FFF);

        // Random single-port traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            pd = 1'($urandom % 2);
            we = pd && ($urandom % 2 == 1);
            a  = {1'($urandom % 2), 4'd0, 8'($urandom % 16)};
            xact($sformatf("rnd%0d", i), pd, we, a, 8'($urandom), 1'b0, 13'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
